operand_fwd_ctrl: RTL

//  Hazard/forwarding controller for the EX-stage operand select datapath of the 5-stage core.
//  - Tracks destination registers of in-flight instructions in EX, MEM and WB shadow slots.
//  - Generates forwarding selects for operand A and operand B.
//  - Detects load-use hazards: stalls decode one cycle and injects a bubble into EX.

---
 rtl/bulbul_pkg.sv | 36 +++
 rtl/operand_fwd_ctrl_fwd_match.sv | 22 ++
 rtl/operand_fwd_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bulbul_pkg.sv
// Shared types for the bulbul core pipeline: forwarding selects and the
// per-stage shadow slot used by the operand forwarding controller.
package bulbul_pkg;

    // Register-file address width, shared with the register file.
    localparam int REG_ADDR_W = 5;

    // EX operand source select.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    // Shadow of one in-flight instruction (EX, MEM or WB).
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
        logic                  use_rs1;
        logic                  use_rs2;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
    } pipe_slot_t;

    // Empty slot; a bubble is simply a slot with valid cleared.
    localparam pipe_slot_t SLOT_EMPTY = '0;

    // True when the slot produces a forwardable result for register rs.
    function automatic logic slot_forwards(input pipe_slot_t s,
                                           input logic [REG_ADDR_W-1:0] rs);
        return s.valid && s.reg_write && (s.rd != '0) && (s.rd == rs);
    endfunction

endpackage

// File: rtl/operand_fwd_ctrl_fwd_match.sv
// Single producer/consumer match: does this slot supply the operand read
// through rs (only when the operand actually comes from a register)?
module fwd_match
    import bulbul_pkg::*;
(
    input  pipe_slot_t            i_slot,
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic                  i_use,
    output logic                  o_hit
);

    // Only the producer-side fields matter for a match.
    logic w_unused;
    assign w_unused = ^{i_slot.is_load, i_slot.use_rs1, i_slot.use_rs2,
                        i_slot.rs1, i_slot.rs2};

    // Hit when the operand is register-sourced and the slot forwards it.
    always_comb begin
        o_hit = i_use && slot_forwards(i_slot, i_rs);
    end

endmodule

// File: rtl/operand_fwd_ctrl.sv
// EX-stage operand forwarding and load-use hazard controller.
// Shadows the EX/MEM/WB destination registers, produces forwarding selects
// for the instruction in EX, and stalls decode one cycle on a load-use hazard.
module operand_fwd_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_is_load_i,
    input  logic                  hold_i,
    input  logic                  flush_i,
    output logic                  id_ready_o,
    output logic                  stall_o,
    output logic                  ex_valid_o,
    output logic [1:0]            ex_fwd_a_o,
    output logic [1:0]            ex_fwd_b_o,
    output logic [CNT_W-1:0]      stall_count_o
);

    import bulbul_pkg::*;

    pipe_slot_t       r_ex;
    pipe_slot_t       r_mem;
    pipe_slot_t       r_wb;
    logic [CNT_W-1:0] r_stall_cnt;

    pipe_slot_t w_id_slot;
    logic       w_lu;
    logic       w_stall;
    logic       w_ready;
    logic       w_mem_hit_a;
    logic       w_mem_hit_b;
    logic       w_wb_hit_a;
    logic       w_wb_hit_b;
    fwd_sel_t   w_fwd_a;
    fwd_sel_t   w_fwd_b;

    // Pack the decode fields into the slot format that enters EX.
    always_comb begin
        w_id_slot           = SLOT_EMPTY;
        w_id_slot.valid     = 1'b1;
        w_id_slot.rd        = id_rd_i;
        w_id_slot.reg_write = id_reg_write_i;
        w_id_slot.is_load   = id_is_load_i;
        w_id_slot.use_rs1   = id_use_rs1_i;
        w_id_slot.use_rs2   = id_use_rs2_i;
        w_id_slot.rs1       = id_rs1_i;
        w_id_slot.rs2       = id_rs2_i;
    end

    // Load-use detection and decode handshake; all forced quiet in reset.
    always_comb begin
        w_lu = id_valid_i && r_ex.is_load &&
               ((id_use_rs1_i && slot_forwards(r_ex, id_rs1_i)) ||
                (id_use_rs2_i && slot_forwards(r_ex, id_rs2_i)));
        w_stall = !rst && (hold_i || (w_lu && !flush_i));
        w_ready = id_valid_i && !w_stall && !flush_i && !rst;
    end

    assign stall_o    = w_stall;
    assign id_ready_o = w_ready;

    fwd_match u_mem_a (.i_slot(r_mem), .i_rs(r_ex.rs1), .i_use(r_ex.use_rs1), .o_hit(w_mem_hit_a));
    fwd_match u_mem_b (.i_slot(r_mem), .i_rs(r_ex.rs2), .i_use(r_ex.use_rs2), .o_hit(w_mem_hit_b));
    fwd_match u_wb_a  (.i_slot(r_wb),  .i_rs(r_ex.rs1), .i_use(r_ex.use_rs1), .o_hit(w_wb_hit_a));
    fwd_match u_wb_b  (.i_slot(r_wb),  .i_rs(r_ex.rs2), .i_use(r_ex.use_rs2), .o_hit(w_wb_hit_b));

    // Operand source selection; MEM (youngest) wins, a load in MEM never forwards.
    always_comb begin
        w_fwd_a = FWD_RF;
        w_fwd_b = FWD_RF;
        if (r_ex.valid && !rst) begin
            if (w_mem_hit_a && !r_mem.is_load) begin
                w_fwd_a = FWD_MEM;
            end else if (w_wb_hit_a) begin
                w_fwd_a = FWD_WB;
            end
            if (w_mem_hit_b && !r_mem.is_load) begin
                w_fwd_b = FWD_MEM;
            end else if (w_wb_hit_b) begin
                w_fwd_b = FWD_WB;
            end
        end
    end

    assign ex_fwd_a_o    = w_fwd_a;
    assign ex_fwd_b_o    = w_fwd_b;
    assign ex_valid_o    = r_ex.valid && !rst;
    assign stall_count_o = r_stall_cnt;

    // Slot shift register: freeze on hold, otherwise advance one stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex  <= SLOT_EMPTY;
            r_mem <= SLOT_EMPTY;
            r_wb  <= SLOT_EMPTY;
        end else if (!hold_i) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_ready ? w_id_slot : SLOT_EMPTY;
        end
    end

    // Saturating count of cycles lost to load-use stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_lu && !hold_i && !flush_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule
